dram_wrr_arbiter: RTL and testbench

Two-port weighted round-robin arbiter in front of the DRAM controller command/data FIFO interface, on `dram_clk`. It shares one DRAM master port between the application port (slave0) and the software sniffer port (slave1). Each port gets a programmable burst quota. An in-order read-tag FIFO steers returning read beats to the port that issued each read.

---
 rtl/dram_arb_pkg.sv | 21 ++
 rtl/dram_arb_tag_fifo.sv | 53 +++++
 rtl/dram_wrr_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_dram_wrr_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and bus widths for the two-port DRAM weighted round-robin arbiter.
package dram_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 144;
    localparam int BE_W   = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } gnt_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rnw;
        logic [DATA_W-1:0] wr_data;
        logic [BE_W-1:0]   wr_be;
    } cmd_t;

endpackage

// File: rtl/dram_arb_tag_fifo.sv
// In-order 1-bit tag FIFO recording which port issued each outstanding read.
// Latency: a pushed tag reaches the head one cycle after the push; head is read from storage.
// Backpressure: push is taken when not full or when popping in the same cycle; pop of an empty FIFO is ignored.
module dram_arb_tag_fifo #(
    parameter int DEPTH = 32
) (
    input  logic dram_clk,
    input  logic dram_rst,
    input  logic push,
    input  logic push_dat,
    input  logic pop,
    output logic head_dat,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge dram_clk) begin
        if (dram_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while the FIFO is non-empty.
    always_ff @(posedge dram_clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/dram_wrr_arbiter.sv
// Two-port weighted round-robin DRAM command arbiter with in-order read-return steering; DRAM_ARB_STATS_EN adds counters.
// Latency: command and ack combinational from registered grant; IDLE->grant 1 cycle, quota switch 1 bubble.
// Backpressure: ack only when DRAM ready and, for reads, a tag slot is free; stalled port keeps the grant.
module dram_wrr_arbiter
    import dram_arb_pkg::*;
#(
    parameter int QUOTA0    = 4,
    parameter int QUOTA1    = 1,
    parameter int RD_BEATS  = 2,
    parameter int TAG_DEPTH = 32
) (
    input  logic              dram_clk,
    input  logic              dram_rst,
    output logic [ADDR_W-1:0] master_cmd_addr,
    output logic              master_cmd_rnw,
    output logic              master_cmd_valid,
    output logic [DATA_W-1:0] master_wr_data,
    output logic [BE_W-1:0]   master_wr_be,
    input  logic [DATA_W-1:0] master_rd_data,
    input  logic              master_rd_valid,
    input  logic              master_fifo_ready,
    input  logic [ADDR_W-1:0] slave0_cmd_addr,
    input  logic              slave0_cmd_rnw,
    input  logic              slave0_cmd_valid,
    input  logic [DATA_W-1:0] slave0_wr_data,
    input  logic [BE_W-1:0]   slave0_wr_be,
    output logic              slave0_ack,
    output logic [DATA_W-1:0] slave0_rd_data,
    output logic              slave0_rd_valid,
    input  logic [ADDR_W-1:0] slave1_cmd_addr,
    input  logic              slave1_cmd_rnw,
    input  logic              slave1_cmd_valid,
    input  logic [DATA_W-1:0] slave1_wr_data,
    input  logic [BE_W-1:0]   slave1_wr_be,
    output logic              slave1_ack,
    output logic [DATA_W-1:0] slave1_rd_data,
    output logic              slave1_rd_valid,
    output logic              rd_underflow,
    output logic [31:0]       stat_cmd0,
    output logic [31:0]       stat_cmd1,
    output logic [31:0]       stat_stall
);

    gnt_state_t state, state_nxt, other_state;
    logic [7:0] cnt, cnt_nxt, quota_last;
    logic       bubble, bubble_nxt;
    cmd_t       s0_cmd, s1_cmd, gnt_cmd;
    logic       gnt_vld, other_vld, accept;

    logic       tag_push, tag_pop, tag_head, tag_fifo_full, tag_empty, tag_full;
    logic [1:0] beat_cnt;
    logic       beat_last;

    assign s0_cmd = {slave0_cmd_addr, slave0_cmd_rnw, slave0_wr_data, slave0_wr_be};
    assign s1_cmd = {slave1_cmd_addr, slave1_cmd_rnw, slave1_wr_data, slave1_wr_be};

    always_ff @(posedge dram_clk) begin
        if (dram_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            bubble <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bubble <= bubble_nxt;
        end
    end

    // Quota expiry hands over through one dead cycle; a switch caused by the
    // granted port going idle is already a non-issuing cycle and needs none.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bubble_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (slave0_cmd_valid)      state_nxt = GNT0;
                else if (slave1_cmd_valid) state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (!bubble) begin
                    if (accept) begin
                        if (cnt == quota_last) begin
                            cnt_nxt = '0;
                            if (other_vld) begin
                                state_nxt  = other_state;
                                bubble_nxt = 1'b1;
                            end
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else if (!gnt_vld) begin
                        cnt_nxt   = '0;
                        state_nxt = other_vld ? other_state : IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_cmd     = '0;
        gnt_vld     = 1'b0;
        other_vld   = 1'b0;
        other_state = IDLE;
        quota_last  = '0;
        case (state)
            GNT0: begin
                gnt_cmd     = s0_cmd;
                gnt_vld     = slave0_cmd_valid;
                other_vld   = slave1_cmd_valid;
                other_state = GNT1;
                quota_last  = 8'(QUOTA0 - 1);
            end
            GNT1: begin
                gnt_cmd     = s1_cmd;
                gnt_vld     = slave1_cmd_valid;
                other_vld   = slave0_cmd_valid;
                other_state = GNT0;
                quota_last  = 8'(QUOTA1 - 1);
            end
            default: ;
        endcase
        accept = gnt_vld & ~bubble & master_fifo_ready & (~gnt_cmd.rnw | ~tag_full);
    end

    assign master_cmd_addr  = gnt_cmd.addr;
    assign master_cmd_rnw   = gnt_cmd.rnw;
    assign master_wr_data   = gnt_cmd.wr_data;
    assign master_wr_be     = gnt_cmd.wr_be;
    assign master_cmd_valid = accept;
    assign slave0_ack       = accept & (state == GNT0);
    assign slave1_ack       = accept & (state == GNT1);

    // A full FIFO still takes a read in the cycle the head tag retires.
    assign beat_last = (beat_cnt == 2'(RD_BEATS - 1));
    assign tag_pop   = master_rd_valid & ~tag_empty & beat_last;
    assign tag_full  = tag_fifo_full & ~tag_pop;
    assign tag_push  = accept & gnt_cmd.rnw;

    dram_arb_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .dram_clk (dram_clk),
        .dram_rst (dram_rst),
        .push     (tag_push),
        .push_dat (state == GNT1),
        .pop      (tag_pop),
        .head_dat (tag_head),
        .full     (tag_fifo_full),
        .empty    (tag_empty)
    );

    always_ff @(posedge dram_clk) begin
        if (dram_rst) begin
            beat_cnt     <= '0;
            rd_underflow <= 1'b0;
        end else if (master_rd_valid) begin
            if (tag_empty)      rd_underflow <= 1'b1;
            else if (beat_last) beat_cnt     <= '0;
            else                beat_cnt     <= beat_cnt + 1'b1;
        end
    end

    assign slave0_rd_data  = master_rd_data;
    assign slave1_rd_data  = master_rd_data;
    assign slave0_rd_valid = master_rd_valid & ~tag_empty & ~tag_head;
    assign slave1_rd_valid = master_rd_valid & ~tag_empty & tag_head;

`ifdef DRAM_ARB_STATS_EN
    logic [31:0] cmd0_q, cmd1_q, stall_q;
    logic        stall;

    assign stall = (slave0_cmd_valid | slave1_cmd_valid) & ~accept;

    always_ff @(posedge dram_clk) begin
        if (dram_rst) begin
            cmd0_q  <= '0;
            cmd1_q  <= '0;
            stall_q <= '0;
        end else begin
            if (slave0_ack && cmd0_q != '1) cmd0_q  <= cmd0_q + 1'b1;
            if (slave1_ack && cmd1_q != '1) cmd1_q  <= cmd1_q + 1'b1;
            if (stall && stall_q != '1)     stall_q <= stall_q + 1'b1;
        end
    end

    assign stat_cmd0  = cmd0_q;
    assign stat_cmd1  = cmd1_q;
    assign stat_stall = stall_q;
`else
    assign stat_cmd0  = '0;
    assign stat_cmd1  = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_dram_wrr_arbiter.sv
// Scenario bench for dram_wrr_arbiter: arbitration pattern, read steering, tag-full stall, backpressure, underflow, reset.
`timescale 1ns/1ps
module tb_dram_wrr_arbiter;

`ifdef DRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         dram_clk = 1'b0;
    logic         dram_rst;
    logic [31:0]  master_cmd_addr;
    logic         master_cmd_rnw, master_cmd_valid;
    logic [143:0] master_wr_data;
    logic [17:0]  master_wr_be;
    logic [143:0] master_rd_data;
    logic         master_rd_valid, master_fifo_ready;
    logic [31:0]  slave0_cmd_addr, slave1_cmd_addr;
    logic         slave0_cmd_rnw, slave0_cmd_valid, slave1_cmd_rnw, slave1_cmd_valid;
    logic [143:0] slave0_wr_data, slave1_wr_data;
    logic [17:0]  slave0_wr_be, slave1_wr_be;
    logic         slave0_ack, slave1_ack, slave0_rd_valid, slave1_rd_valid;
    logic [143:0] slave0_rd_data, slave1_rd_data;
    logic         rd_underflow;
    logic [31:0]  stat_cmd0, stat_cmd1, stat_stall;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 dram_clk = ~dram_clk;

    dram_wrr_arbiter #(
        .QUOTA0(4), .QUOTA1(1), .RD_BEATS(2), .TAG_DEPTH(4)
    ) dut (
        .dram_clk(dram_clk), .dram_rst(dram_rst),
        .master_cmd_addr(master_cmd_addr), .master_cmd_rnw(master_cmd_rnw),
        .master_cmd_valid(master_cmd_valid), .master_wr_data(master_wr_data),
        .master_wr_be(master_wr_be), .master_rd_data(master_rd_data),
        .master_rd_valid(master_rd_valid), .master_fifo_ready(master_fifo_ready),
        .slave0_cmd_addr(slave0_cmd_addr), .slave0_cmd_rnw(slave0_cmd_rnw),
        .slave0_cmd_valid(slave0_cmd_valid), .slave0_wr_data(slave0_wr_data),
        .slave0_wr_be(slave0_wr_be), .slave0_ack(slave0_ack),
        .slave0_rd_data(slave0_rd_data), .slave0_rd_valid(slave0_rd_valid),
        .slave1_cmd_addr(slave1_cmd_addr), .slave1_cmd_rnw(slave1_cmd_rnw),
        .slave1_cmd_valid(slave1_cmd_valid), .slave1_wr_data(slave1_wr_data),
        .slave1_wr_be(slave1_wr_be), .slave1_ack(slave1_ack),
        .slave1_rd_data(slave1_rd_data), .slave1_rd_valid(slave1_rd_valid),
        .rd_underflow(rd_underflow),
        .stat_cmd0(stat_cmd0), .stat_cmd1(stat_cmd1), .stat_stall(stat_stall)
    );

    task automatic tick();
        @(posedge dram_clk);
        #1;
    endtask

    task automatic idle_inputs();
        master_rd_data    = '0;
        master_rd_valid   = 1'b0;
        master_fifo_ready = 1'b0;
        slave0_cmd_addr   = '0; slave0_cmd_rnw = 1'b0; slave0_cmd_valid = 1'b0;
        slave0_wr_data    = '0; slave0_wr_be   = '0;
        slave1_cmd_addr   = '0; slave1_cmd_rnw = 1'b0; slave1_cmd_valid = 1'b0;
        slave1_wr_data    = '0; slave1_wr_be   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        dram_rst = 1'b1;
        tick();
        tick();
        dram_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge dram_clk);
        checks++;
        if ({slave0_ack, slave1_ack, master_cmd_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ack: got %b want 000", {slave0_ack, slave1_ack, master_cmd_valid});
        end
        checks++;
        if (master_cmd_addr !== 32'd0 || master_wr_data !== 144'd0 || master_wr_be !== 18'd0 || master_cmd_rnw !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd: got addr %h rnw %b want 0", master_cmd_addr, master_cmd_rnw);
        end
        checks++;
        if ({slave0_rd_valid, slave1_rd_valid, rd_underflow} !== 3'b000 || slave0_rd_data !== 144'd0) begin
            errors++;
            $display("FAIL reset_rd: got %b want 000", {slave0_rd_valid, slave1_rd_valid, rd_underflow});
        end
        checks++;
        if (stat_cmd0 !== 32'd0 || stat_cmd1 !== 32'd0 || stat_stall !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0", stat_cmd0, stat_cmd1, stat_stall);
        end
        tick();
    endtask

    task automatic test_wrr();
        int pat[14] = '{-1, 0, 0, 0, 0, -1, 1, -1, 0, 0, 0, 0, -1, 1};
        int got, want;
        logic [31:0] a0, a1;
        logic [143:0] d0, d1;
        do_reset();
        exp_q = {};
        foreach (pat[i]) exp_q.push_back(pat[i]);
        master_fifo_ready = 1'b1;
        slave0_cmd_valid = 1'b1; slave1_cmd_valid = 1'b1;
        slave0_wr_be = 18'h30F0F; slave1_wr_be = 18'h05A5A;
        for (int c = 0; c < 14; c++) begin
            a0 = 32'h1000_0000 + 32'(c); a1 = 32'h2000_0000 + 32'(c);
            d0 = {16'hA0A0, 128'(c)};    d1 = {16'hB1B1, 128'(c)};
            slave0_cmd_addr = a0; slave0_wr_data = d0;
            slave1_cmd_addr = a1; slave1_wr_data = d1;
            @(negedge dram_clk);
            got = (slave0_ack && slave1_ack) ? 2 : slave0_ack ? 0 : slave1_ack ? 1 : -1;
            want = exp_q.pop_front();
            checks++;
            if (got != want) begin
                errors++;
                $display("FAIL wrr_grant cycle %0d: got port %0d want %0d", c, got, want);
            end
            checks++;
            if (master_cmd_valid !== (want >= 0)) begin
                errors++;
                $display("FAIL wrr_cmd_valid cycle %0d: got %b want %b", c, master_cmd_valid, want >= 0);
            end
            if (want == 0 || want == 1) begin
                checks++;
                if (master_cmd_addr !== (want == 0 ? a0 : a1) || master_wr_data !== (want == 0 ? d0 : d1) ||
                    master_wr_be !== (want == 0 ? 18'h30F0F : 18'h05A5A) || master_cmd_rnw !== 1'b0) begin
                    errors++;
                    $display("FAIL wrr_cmd_mux cycle %0d: got addr %h want %h", c, master_cmd_addr, want == 0 ? a0 : a1);
                end
            end
            tick();
        end
        checks++;
        if (stat_cmd0 !== (STATS ? 32'd8 : 32'd0) || stat_cmd1 !== (STATS ? 32'd2 : 32'd0) ||
            stat_stall !== (STATS ? 32'd4 : 32'd0)) begin
            errors++;
            $display("FAIL wrr_stats: got %0d:%0d stall %0d want 8:2 stall 4 (or 0s)", stat_cmd0, stat_cmd1, stat_stall);
        end
        idle_inputs();
    endtask

    task automatic test_read_steer();
        int n0 = 0, n1 = 0, beats = 0, want;
        logic beat;
        logic [143:0] dat;
        do_reset();
        exp_q = {};
        master_fifo_ready = 1'b1;
        slave0_cmd_rnw = 1'b1; slave1_cmd_rnw = 1'b1;
        for (int c = 0; c < 60 && beats < 10; c++) begin
            slave1_cmd_valid = (n1 < 3);
            slave0_cmd_valid = (n1 >= 3 && n0 < 2);
            beat = (exp_q.size() > 0);
            dat = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
            master_rd_valid = beat;
            master_rd_data  = dat;
            @(negedge dram_clk);
            if (beat) begin
                want = exp_q.pop_front();
                checks++;
                if (slave0_rd_valid !== (want == 0) || slave1_rd_valid !== (want == 1)) begin
                    errors++;
                    $display("FAIL steer beat %0d: got v0=%b v1=%b want port %0d", beats, slave0_rd_valid, slave1_rd_valid, want);
                end
                checks++;
                if (slave0_rd_data !== dat || slave1_rd_data !== dat) begin
                    errors++;
                    $display("FAIL steer_data beat %0d: got %h want %h", beats, slave0_rd_data, dat);
                end
                beats++;
            end
            if (slave1_ack) begin n1++; exp_q.push_back(1); exp_q.push_back(1); end
            if (slave0_ack) begin n0++; exp_q.push_back(0); exp_q.push_back(0); end
            tick();
        end
        checks++;
        if (beats != 10 || n0 != 2 || n1 != 3) begin
            errors++;
            $display("FAIL steer_count: got beats %0d reads %0d/%0d want 10 beats reads 2/3", beats, n0, n1);
        end
        idle_inputs();
    endtask

    task automatic test_tag_full();
        int n = 0;
        logic released = 1'b0;
        do_reset();
        master_fifo_ready = 1'b1;
        slave0_cmd_valid = 1'b1; slave0_cmd_rnw = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge dram_clk);
            if (slave0_ack) n++;
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL tagfull_reads: got %0d acks want 4", n);
        end
        slave0_cmd_rnw = 1'b0;
        @(negedge dram_clk);
        checks++;
        if (slave0_ack !== 1'b1) begin
            errors++;
            $display("FAIL tagfull_write: got ack %b want 1", slave0_ack);
        end
        tick();
        slave0_cmd_rnw = 1'b1;
        @(negedge dram_clk);
        checks++;
        if (slave0_ack !== 1'b0) begin
            errors++;
            $display("FAIL tagfull_hold: got ack %b want 0", slave0_ack);
        end
        tick();
        for (int b = 0; b < 2; b++) begin
            master_rd_valid = 1'b1;
            @(negedge dram_clk);
            checks++;
            if (slave0_rd_valid !== 1'b1 || slave1_rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL tagfull_beat %0d: got v0=%b v1=%b want 1 0", b, slave0_rd_valid, slave1_rd_valid);
            end
            if (slave0_ack) released = 1'b1;
            tick();
        end
        master_rd_valid = 1'b0;
        for (int c = 0; c < 3 && !released; c++) begin
            @(negedge dram_clk);
            if (slave0_ack) released = 1'b1;
            tick();
        end
        checks++;
        if (!released) begin
            errors++;
            $display("FAIL tagfull_release: got no ack want 5th read acked");
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        master_fifo_ready = 1'b1;
        slave0_cmd_valid = 1'b1; slave1_cmd_valid = 1'b1;
        tick();
        @(negedge dram_clk);
        checks++;
        if (slave0_ack !== 1'b1) begin
            errors++;
            $display("FAIL stall_first: got ack0 %b want 1", slave0_ack);
        end
        tick();
        master_fifo_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge dram_clk);
            checks++;
            if ({slave0_ack, slave1_ack, master_cmd_valid} !== 3'b000) begin
                errors++;
                $display("FAIL stall_noack cycle %0d: got %b want 000", c, {slave0_ack, slave1_ack, master_cmd_valid});
            end
            tick();
        end
        checks++;
        if (stat_stall !== (STATS ? 32'd11 : 32'd0) || stat_cmd0 !== (STATS ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL stall_stats: got stall %0d cmd0 %0d want 11 1 (or 0s)", stat_stall, stat_cmd0);
        end
        master_fifo_ready = 1'b1;
        @(negedge dram_clk);
        checks++;
        if (slave0_ack !== 1'b1 || slave1_ack !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume: got ack0 %b ack1 %b want 1 0", slave0_ack, slave1_ack);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_underflow();
        logic issued = 1'b0;
        do_reset();
        master_rd_valid = 1'b1;
        @(negedge dram_clk);
        checks++;
        if (slave0_rd_valid !== 1'b0 || slave1_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL underflow_drop: got v0=%b v1=%b want 0 0", slave0_rd_valid, slave1_rd_valid);
        end
        tick();
        master_rd_valid = 1'b0;
        repeat (3) tick();
        @(negedge dram_clk);
        checks++;
        if (rd_underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky: got %b want 1", rd_underflow);
        end
        master_fifo_ready = 1'b1;
        slave0_cmd_valid = 1'b1; slave0_cmd_rnw = 1'b1;
        for (int c = 0; c < 4 && !issued; c++) begin
            tick();
            @(negedge dram_clk);
            if (slave0_ack) issued = 1'b1;
        end
        tick();
        slave0_cmd_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            master_rd_valid = 1'b1;
            @(negedge dram_clk);
            checks++;
            if (slave0_rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL underflow_beatcnt beat %0d: got v0=%b want 1 (issued=%b)", b, slave0_rd_valid, issued);
            end
            tick();
        end
        master_rd_valid = 1'b0;
        do_reset();
        @(negedge dram_clk);
        checks++;
        if (rd_underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b want 0", rd_underflow);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int n = 0;
        do_reset();
        master_fifo_ready = 1'b1;
        slave0_cmd_valid = 1'b1; slave0_cmd_rnw = 1'b1;
        slave0_cmd_addr = 32'hDEAD_0000;
        for (int c = 0; c < 10 && n < 3; c++) begin
            @(negedge dram_clk);
            if (slave0_ack) n++;
            tick();
        end
        idle_inputs();
        dram_rst = 1'b1;
        tick();
        dram_rst = 1'b0;
        @(negedge dram_clk);
        checks++;
        if ({slave0_ack, slave1_ack, master_cmd_valid, slave0_rd_valid, slave1_rd_valid, rd_underflow} !== 6'd0 ||
            master_cmd_addr !== 32'd0 || stat_cmd0 !== 32'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got acks %b%b addr %h cmd0 %0d want all 0 (reads issued %0d)",
                     slave0_ack, slave1_ack, master_cmd_addr, stat_cmd0, n);
        end
        tick();
        master_fifo_ready = 1'b1;
        slave0_cmd_valid = 1'b1;
        @(negedge dram_clk);
        checks++;
        if (slave0_ack !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: got ack %b want 0", slave0_ack);
        end
        tick();
        @(negedge dram_clk);
        checks++;
        if (slave0_ack !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant: got ack %b want 1", slave0_ack);
        end
        tick();
        idle_inputs();
        master_rd_valid = 1'b1;
        @(negedge dram_clk);
        checks++;
        if (slave0_rd_valid !== 1'b0 || slave1_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flush: got v0=%b v1=%b want 0 0", slave0_rd_valid, slave1_rd_valid);
        end
        tick();
        master_rd_valid = 1'b0;
        @(negedge dram_clk);
        checks++;
        if (rd_underflow !== 1'b1) begin
            errors++;
            $display("FAIL midrst_underflow: got %b want 1", rd_underflow);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        dram_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_wrr();
        test_read_steer();
        test_tag_full();
        test_stall();
        test_underflow();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
